// File: rtl/wb_stage.sv
// wb_stage: writeback stage. Registers ALU results and flags, owns the register file,
// sequences LD/ST through a one-cycle data memory port, and latches the OUT port.
module wb_stage #(
  parameter int DATA_W = 8,
  parameter int RF_AW  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_ex,
  input  logic [4:0]        op_dec,
  input  logic [RF_AW-1:0]  rd_addr,
  input  logic [DATA_W-1:0] ans_tmp,
  input  logic [DATA_W-1:0] data_out_buff,
  input  logic [3:0]        flag_ex,
  input  logic [DATA_W-1:0] st_data,
  input  logic [RF_AW-1:0]  rs_addr,
  input  logic [RF_AW-1:0]  rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] ans_ex,
  output logic [DATA_W-1:0] data_out,
  output logic [3:0]        flag_reg,
  output logic              busy,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int N = 2**RF_AW;
  typedef enum logic {IDLE, LD_WAIT} state_t;
  state_t state_q, state_d;
  logic [RF_AW-1:0]  ld_rd_q, ld_rd_d;
  logic [DATA_W-1:0] rf_q [N];
  logic [DATA_W-1:0] rf_d [N];
  logic [DATA_W-1:0] ans_ex_q, ans_ex_d, data_out_q, data_out_d;
  logic [3:0]        flag_q, flag_d;
  logic              accept, is_ld, is_st, is_out, rf_op, wr_en;
  logic [RF_AW-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;
  always_comb begin
    busy      = state_q == LD_WAIT;
    accept    = rst_n & valid_ex & ~busy;
    is_ld     = op_dec == 5'b10100;
    is_st     = op_dec == 5'b10101;
    is_out    = op_dec == 5'b10111;
    rf_op     = (~op_dec[4] & (op_dec[2:0] != 3'b011)) | (op_dec == 5'b10110) |
                (op_dec == 5'b11001) | (op_dec == 5'b11010) | (op_dec == 5'b11011);
    mem_addr  = ans_tmp;
    mem_wdata = st_data;
    mem_re    = accept & is_ld;
    mem_we    = accept & is_st;
    // LD completion owns the single write port while busy; accept is blocked then
    wr_en     = rst_n & (busy | (accept & rf_op));
    wr_addr   = busy ? ld_rd_q : rd_addr;
    wr_data   = busy ? mem_rdata : ans_tmp;
    rf_d      = rf_q;
    if (wr_en) rf_d[wr_addr] = wr_data;
    rs_data   = (wr_en && wr_addr == rs_addr) ? wr_data : rf_q[rs_addr];
    rt_data   = (wr_en && wr_addr == rt_addr) ? wr_data : rf_q[rt_addr];
    state_d   = (!busy && accept && is_ld) ? LD_WAIT : IDLE;
    ld_rd_d   = (accept && is_ld) ? rd_addr : ld_rd_q;
    ans_ex_d  = accept ? ans_tmp : ans_ex_q;
    data_out_d = (accept && is_out) ? data_out_buff : data_out_q;
    flag_d    = (accept && op_dec[4:2] != 3'b111) ? flag_ex : flag_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ld_rd_q    <= '0;
      rf_q       <= '{default: '0};
      ans_ex_q   <= '0;
      data_out_q <= '0;
      flag_q     <= '0;
    end else begin
      state_q    <= state_d;
      ld_rd_q    <= ld_rd_d;
      rf_q       <= rf_d;
      ans_ex_q   <= ans_ex_d;
      data_out_q <= data_out_d;
      flag_q     <= flag_d;
    end
  end
  assign ans_ex   = ans_ex_q;
  assign data_out = data_out_q;
  assign flag_reg = flag_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed vector table plus hand-written LD and reset-during-LD sequences.
module tb_wb_stage;
  logic       clk = 0, rst_n = 0, valid_ex = 0, busy, mem_we, mem_re;
  logic [4:0] op_dec = 0;
  logic [2:0] rd_addr = 0, rs_addr = 0, rt_addr = 0;
  logic [7:0] ans_tmp = 0, data_out_buff = 0, st_data = 0, mem_rdata = 0;
  logic [3:0] flag_ex = 0, flag_reg;
  logic [7:0] rs_data, rt_data, ans_ex, data_out, mem_addr, mem_wdata;
  int tests = 0, fails = 0;

  wb_stage dut (.clk(clk), .rst_n(rst_n), .valid_ex(valid_ex), .op_dec(op_dec),
    .rd_addr(rd_addr), .ans_tmp(ans_tmp), .data_out_buff(data_out_buff), .flag_ex(flag_ex),
    .st_data(st_data), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data),
    .rt_data(rt_data), .ans_ex(ans_ex), .data_out(data_out), .flag_reg(flag_reg),
    .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] op;
    logic [2:0] rd;
    logic [7:0] ans, dob;
    logic [3:0] flg;
    logic [7:0] st;
    logic [2:0] rs;
    logic [7:0] exp_rs;
    logic       exp_re, exp_we;
    logic [7:0] exp_ma, exp_wd, exp_ans, exp_dout;
    logic [3:0] exp_flag;
  } vec_t;
  vec_t vecs [13];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{1, 5'b00000, 3, 8'h5A, 8'h00, 4'b0001, 8'h00, 3, 8'h5A, 0, 0, 8'h00, 8'h00, 8'h5A, 8'h00, 4'b0001};
    vecs[1]  = '{0, 5'b00000, 0, 8'h00, 8'h00, 4'b0000, 8'h00, 3, 8'h5A, 0, 0, 8'h00, 8'h00, 8'h5A, 8'h00, 4'b0001};
    vecs[2]  = '{1, 5'b10101, 4, 8'h10, 8'h00, 4'b0000, 8'h77, 4, 8'h00, 0, 1, 8'h10, 8'h77, 8'h10, 8'h00, 4'b0000};
    vecs[3]  = '{1, 5'b10111, 4, 8'h10, 8'hAB, 4'b0010, 8'h00, 4, 8'h00, 0, 0, 8'h00, 8'h00, 8'h10, 8'hAB, 4'b0010};
    vecs[4]  = '{1, 5'b00000, 4, 8'h33, 8'h11, 4'b1010, 8'h00, 4, 8'h33, 0, 0, 8'h00, 8'h00, 8'h33, 8'hAB, 4'b1010};
    vecs[5]  = '{1, 5'b11100, 6, 8'h44, 8'h00, 4'b0101, 8'h00, 6, 8'h00, 0, 0, 8'h00, 8'h00, 8'h44, 8'hAB, 4'b1010};
    vecs[6]  = '{1, 5'b00100, 6, 8'h0F, 8'h00, 4'b0010, 8'h00, 6, 8'h0F, 0, 0, 8'h00, 8'h00, 8'h0F, 8'hAB, 4'b0010};
    vecs[7]  = '{1, 5'b10000, 1, 8'hFF, 8'h00, 4'b0001, 8'h00, 1, 8'h00, 0, 0, 8'h00, 8'h00, 8'hFF, 8'hAB, 4'b0001};
    vecs[8]  = '{1, 5'b11000, 1, 8'hFF, 8'h00, 4'b0011, 8'h00, 1, 8'h00, 0, 0, 8'h00, 8'h00, 8'hFF, 8'hAB, 4'b0011};
    vecs[9]  = '{0, 5'b00000, 1, 8'h00, 8'h00, 4'b0000, 8'h00, 1, 8'h00, 0, 0, 8'h00, 8'h00, 8'hFF, 8'hAB, 4'b0011};
    vecs[10] = '{1, 5'b11011, 7, 8'h81, 8'h00, 4'b0000, 8'h00, 7, 8'h81, 0, 0, 8'h00, 8'h00, 8'h81, 8'hAB, 4'b0000};
    vecs[11] = '{1, 5'b00011, 7, 8'h99, 8'h00, 4'b0100, 8'h00, 7, 8'h81, 0, 0, 8'h00, 8'h00, 8'h99, 8'hAB, 4'b0100};
    vecs[12] = '{1, 5'b10110, 0, 8'h5C, 8'h00, 4'b0000, 8'h00, 0, 8'h5C, 0, 0, 8'h00, 8'h00, 8'h5C, 8'hAB, 4'b0000};

    repeat (2) @(posedge clk);
    #1;
    check("rst ans_ex", ans_ex, 8'h00);
    check("rst data_out", data_out, 8'h00);
    check("rst flag", {4'h0, flag_reg}, 8'h00);
    check("rst busy", {7'h0, busy}, 8'h00);
    check("rst strobes", {6'h0, mem_re, mem_we}, 8'h00);
    @(negedge clk) rst_n = 1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      valid_ex = vecs[i].v; op_dec = vecs[i].op; rd_addr = vecs[i].rd; ans_tmp = vecs[i].ans;
      data_out_buff = vecs[i].dob; flag_ex = vecs[i].flg; st_data = vecs[i].st; rs_addr = vecs[i].rs;
      #1;
      check($sformatf("v%0d rs_data", i), rs_data, vecs[i].exp_rs);
      check($sformatf("v%0d mem_re", i), {7'h0, mem_re}, {7'h0, vecs[i].exp_re});
      check($sformatf("v%0d mem_we", i), {7'h0, mem_we}, {7'h0, vecs[i].exp_we});
      if (vecs[i].exp_re | vecs[i].exp_we) begin
        check($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].exp_ma);
        check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].exp_wd);
      end
      check($sformatf("v%0d busy", i), {7'h0, busy}, 8'h00);
      @(posedge clk);
      #1;
      check($sformatf("v%0d ans_ex", i), ans_ex, vecs[i].exp_ans);
      check($sformatf("v%0d data_out", i), data_out, vecs[i].exp_dout);
      check($sformatf("v%0d flag_reg", i), {4'h0, flag_reg}, {4'h0, vecs[i].exp_flag});
    end

    // LD then an ADD held across the busy cycle
    @(negedge clk);
    valid_ex = 1; op_dec = 5'b10100; rd_addr = 5; ans_tmp = 8'h20; flag_ex = 4'b0001; rs_addr = 5;
    #1;
    check("ld mem_re", {7'h0, mem_re}, 8'h01);
    check("ld mem_we", {7'h0, mem_we}, 8'h00);
    check("ld mem_addr", mem_addr, 8'h20);
    @(negedge clk);
    op_dec = 5'b00000; rd_addr = 2; ans_tmp = 8'h66; flag_ex = 4'b1000; mem_rdata = 8'hC3; rt_addr = 2;
    #1;
    check("ld busy", {7'h0, busy}, 8'h01);
    check("ld bypass", rs_data, 8'hC3);
    check("ld no re in wait", {7'h0, mem_re}, 8'h00);
    @(posedge clk);
    #1;
    check("ld ans_ex held", ans_ex, 8'h20);
    check("ld flag", {4'h0, flag_reg}, 8'h01);
    @(negedge clk);
    #1;
    check("ld busy clr", {7'h0, busy}, 8'h00);
    check("ld rf5", rs_data, 8'hC3);
    check("add bypass rt", rt_data, 8'h66);
    @(posedge clk);
    #1;
    check("add after ld ans", ans_ex, 8'h66);
    check("add after ld flag", {4'h0, flag_reg}, 8'h08);

    // reset while in LD_WAIT drops the load
    @(negedge clk);
    op_dec = 5'b10100; rd_addr = 2; ans_tmp = 8'h30; rs_addr = 2;
    @(negedge clk);
    valid_ex = 0; mem_rdata = 8'hEE; rst_n = 0;
    #1;
    check("rld busy before", {7'h0, busy}, 8'h01);
    @(posedge clk);
    #1;
    check("rld busy", {7'h0, busy}, 8'h00);
    check("rld rf2", rs_data, 8'h00);
    check("rld ans_ex", ans_ex, 8'h00);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    check("rld rf2 after", rs_data, 8'h00);
    check("rld busy after", {7'h0, busy}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Execute-to-writeback stage directly downstream of the 8-bit ALU.
- Registers ALU results and flags, and owns the 8-entry register file, which feeds A/B operands upstream.
- Sequences LD/ST through a one-cycle-latency data memory port and latches the OUT port.
- Feeds `ans_ex` and `data_out` back to the ALU for hold-type opcodes.

Parameters:
- DATA_W, 8, datapath width
- RF_AW, 3, register file address width (2**RF_AW entries)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- valid_ex  in  1  ALU outputs valid this cycle
- op_dec  in  5  decoded opcode of the instruction in EX
- rd_addr  in  RF_AW  destination register
- ans_tmp  in  DATA_W  ALU result
- data_out_buff  in  DATA_W  ALU output-port candidate
- flag_ex  in  4  ALU flags {P,V,Z,C}
- st_data  in  DATA_W  store data (rt value)
- rs_addr, rt_addr  in  RF_AW  read addresses
- rs_data, rt_data  out  DATA_W  read data (combinational)
- ans_ex  out  DATA_W  last accepted result (registered)
- data_out  out  DATA_W  output port latch
- flag_reg  out  4  architectural flags
- busy  out  1  stage cannot accept; upstream holds
- mem_addr  out  DATA_W  data memory address
- mem_wdata  out  DATA_W  data memory write data
- mem_we  out  1  data memory write strobe
- mem_re  out  1  data memory read strobe
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_re

Behaviour:

Acceptance:
- accept = valid_ex & ~busy.
- Nothing updates on cycles without accept, except LD completion.

Reset (rst_n low at a clock edge):
- All RF entries, ans_ex, data_out and flag_reg clear to 0.
- busy=0, mem_we=0, mem_re=0.
- FSM goes to IDLE. An in-flight LD is dropped with no RF write.

FSM states: IDLE, LD_WAIT.
- IDLE + accept + LD (10100) -> LD_WAIT. Latch rd_addr.
- LD_WAIT -> IDLE unconditionally after one cycle. Write mem_rdata to the latched rd.
- busy=1 exactly while in LD_WAIT, so an LD costs 2 cycles.
- valid_ex during LD_WAIT is not accepted and has no effect.

Memory port (combinational from inputs in IDLE):
- mem_addr = ans_tmp.
- mem_re = accept & op==10100.
- mem_we = accept & op==10101; mem_wdata = st_data.
- mem_addr/mem_wdata are don't-care when neither strobe is high. mem_we is a single cycle.

RF write on accept, at the clock edge, rd <= ans_tmp for:
- ADD/ADI 00000/01000
- SUB/SBI 00001/01001
- MOV/MVI 00010/01010
- AND/ANI 00100/01100
- OR/ORI 00101/01101
- XOR/XRI 00110/01110
- NOT/NTI 00111/01111
- IN 10110
- LS 11001, RS 11010, RSA 11011

No RF write on accept for:
- LD (deferred to LD_WAIT), ST, OUT 10111.
- 10000, 10001, 11000, 111xx.
- Any unlisted opcode.

Output port and result register:
- OUT: data_out <= data_out_buff on accept; otherwise data_out holds.
- ans_ex <= ans_tmp on every accept, including hold opcodes where ans_tmp==ans_ex.
- LD completion writes the RF only, not ans_ex.

Flags:
- flag_reg <= flag_ex on accept, except when op_dec[4:2]==111, where flag_reg holds.

Read ports:
- rs_data/rt_data are asynchronous reads with write-first bypass.
- If a write to address X is occurring this cycle (ALU write or LD completion) and a read port addresses X, it returns the data being written.
- At most one RF write per cycle: LD completion and accept are mutually exclusive via busy.

Timing:
- Results visible in the RF/ans_ex one cycle after accept; via bypass in the same cycle.

Test Plan:
- Reset then ADD: rst_n=0 for 2 clks -> all outputs 0, busy=0. Then valid_ex=1, op=00000, rd=3, ans_tmp=8'h5A, flag_ex=4'b0001 -> next cycle RF[3]=5A, ans_ex=5A, flag_reg=0001; same cycle rs_addr=3 reads 5A via bypass.
- LD sequencing: op=10100, ans_tmp=8'h20, rd=5 -> mem_re=1, mem_addr=20. Next cycle busy=1; mem_rdata=8'hC3 -> RF[5]=C3 after that edge. A valid_ex=1 ADD held during busy is accepted only once busy=0.
- ST and OUT: op=10101, ans_tmp=8'h10, st_data=8'h77 -> mem_we=1 for 1 cycle, addr 10, wdata 77, no RF change. Then op=10111, data_out_buff=8'hAB -> data_out=AB; a later ADD leaves data_out=AB.
- Flag hold: flag_reg=4'b1010. op=11100 with flag_ex=4'b0101 -> flag_reg stays 1010. op=00100 with flag_ex=4'b0010 -> flag_reg=0010.
- Reset mid-LD: accept LD rd=2, assert rst_n=0 during LD_WAIT -> RF[2]=0, busy=0, state IDLE.
- No-write opcodes: op=10000 and 11000 with rd=1, ans_tmp=8'hFF -> RF[1] unchanged; ans_ex=FF.
